// File: rtl/io_bank_pkg.sv
// Shared constants for the io_bank_ctrl slice: config field layout and reconfiguration FSM states.
package io_bank_pkg;

  localparam int CFG_W         = 4;
  localparam int CFG_OUT_EN    = 0;
  localparam int CFG_IN_EN     = 1;
  localparam int CFG_REG_OUT   = 2;
  localparam int CFG_DRV_FORCE = 3;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/io_bank_ctrl_if.sv
// Fabric/pad/config bundle of io_bank_ctrl. Defining IO_LOOPBACK_EN adds the Loopback vector.
interface io_bank_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CFG_W  = 4
);
  logic [NUM_CH*CFG_W-1:0] ConfigBits;
  logic [NUM_CH-1:0]       I;
  logic [NUM_CH-1:0]       T;
  logic [NUM_CH-1:0]       O;
  logic [NUM_CH-1:0]       Q;
  logic [NUM_CH-1:0]       I_top;
  logic [NUM_CH-1:0]       T_top;
  logic [NUM_CH-1:0]       O_top;
  logic                    ReconfigBusy;

`ifdef IO_LOOPBACK_EN
  logic [NUM_CH-1:0]       Loopback;

  modport master (
    output ConfigBits, I, T, O_top, Loopback,
    input  O, Q, I_top, T_top, ReconfigBusy
  );
  modport slave (
    input  ConfigBits, I, T, O_top, Loopback,
    output O, Q, I_top, T_top, ReconfigBusy
  );
`else
  modport master (
    output ConfigBits, I, T, O_top,
    input  O, Q, I_top, T_top, ReconfigBusy
  );
  modport slave (
    input  ConfigBits, I, T, O_top,
    output O, Q, I_top, T_top, ReconfigBusy
  );
`endif

endinterface

// File: rtl/io_bank_channel.sv
// One IO channel: output mux/registers with hi-Z hold and an input synchroniser with clear.
// IO_LOOPBACK_EN adds a path feeding the channel's own drive value back to O/Q.
module io_bank_channel
  import io_bank_pkg::*;
#(
  parameter int CH_CFG_W    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_CFG_W-1:0] cfg,
  input  logic                i,
  input  logic                t,
  input  logic                o_top,
`ifdef IO_LOOPBACK_EN
  input  logic                loopback,
`endif
  input  logic                hold_hiz,
  input  logic                sync_clr,
  output logic                o,
  output logic                q,
  output logic                i_top,
  output logic                t_top
);

  logic out_en, in_en, reg_out, drv_force;
  logic t_eff, park, drv_i, drv_t, pad_in, lb_on;
  logic oreg_i_q, oreg_i_d, oreg_t_q, oreg_t_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  assign out_en    = cfg[CFG_OUT_EN];
  assign in_en     = cfg[CFG_IN_EN];
  assign reg_out   = cfg[CFG_REG_OUT];
  assign drv_force = cfg[CFG_DRV_FORCE];

  // A parked channel also loads its output registers with the idle pattern,
  // so a newly enabled registered output never replays stale data.
  always_comb begin
    t_eff    = drv_force ? 1'b0 : t;
    park     = hold_hiz | ~out_en;
    oreg_i_d = park ? 1'b0 : i;
    oreg_t_d = park ? 1'b1 : t_eff;
    if (park) begin
      drv_i = 1'b0;
      drv_t = 1'b1;
    end else if (reg_out) begin
      drv_i = oreg_i_q;
      drv_t = oreg_t_q;
    end else begin
      drv_i = i;
      drv_t = t_eff;
    end
  end

`ifdef IO_LOOPBACK_EN
  assign lb_on = loopback & ~hold_hiz;
`else
  assign lb_on = 1'b0;
`endif

  assign pad_in = lb_on ? drv_i : o_top;
  assign i_top  = drv_i;
  assign t_top  = drv_t | lb_on;
  assign o      = in_en & pad_in;
  assign q      = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = '0;
    if (in_en && !sync_clr) begin
      sync_d[0] = pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[s] = sync_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oreg_i_q <= 1'b0;
      oreg_t_q <= 1'b1;
      sync_q   <= '0;
    end else begin
      oreg_i_q <= oreg_i_d;
      oreg_t_q <= oreg_t_d;
      sync_q   <= sync_d;
    end
  end

endmodule

// File: rtl/io_bank_ctrl.sv
// Multi-channel IO bank with glitch-safe reconfiguration (changed channels drained hi-Z, then applied).
// Defining IO_LOOPBACK_EN enables per-channel internal loopback via the interface Loopback vector.
module io_bank_ctrl
  import io_bank_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CFG_W        = io_bank_pkg::CFG_W,
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input logic           UserCLK,
  input logic           Reset,
  io_bank_ctrl_if.slave bus
);

  localparam int              TOT_W      = NUM_CH * CFG_W;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  fsm_state_e        state_q, state_d;
  logic [TOT_W-1:0]  active_q, active_d;
  logic [TOT_W-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] diff_active, hold_mask, clr_mask;
  logic [NUM_CH-1:0] o_vec, q_vec, i_top_vec, t_top_vec;

  // Any further change while draining restarts the full drain period.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.ConfigBits != active_q) begin
          pending_d = bus.ConfigBits;
          mask_d    = diff_active;
          cnt_d     = DRAIN_LOAD;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.ConfigBits != pending_q) begin
          pending_d = bus.ConfigBits;
          mask_d    = mask_q | diff_active;
          cnt_d     = DRAIN_LOAD;
        end else if (cnt_q == '0) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      APPLY: begin
        active_d = pending_q;
        mask_d   = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      active_q  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign hold_mask = busy_q ? mask_q : '0;
  assign clr_mask  = (state_q == APPLY) ? mask_q : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
      assign diff_active[gi] =
        (bus.ConfigBits[gi*CFG_W +: CFG_W] != active_q[gi*CFG_W +: CFG_W]);

      io_bank_channel #(
        .CH_CFG_W    (CFG_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk      (UserCLK),
        .rst      (Reset),
        .cfg      (active_q[gi*CFG_W +: CFG_W]),
        .i        (bus.I[gi]),
        .t        (bus.T[gi]),
        .o_top    (bus.O_top[gi]),
`ifdef IO_LOOPBACK_EN
        .loopback (bus.Loopback[gi]),
`endif
        .hold_hiz (hold_mask[gi]),
        .sync_clr (clr_mask[gi]),
        .o        (o_vec[gi]),
        .q        (q_vec[gi]),
        .i_top    (i_top_vec[gi]),
        .t_top    (t_top_vec[gi])
      );
    end
  endgenerate

  assign bus.O            = o_vec;
  assign bus.Q            = q_vec;
  assign bus.I_top        = i_top_vec;
  assign bus.T_top        = t_top_vec;
  assign bus.ReconfigBusy = busy_q;

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Bench for io_bank_ctrl: directed scenarios plus randomized traffic compared against a
// cycle-level reference model of the configuration, drain and IO rules.
module tb_io_bank_ctrl;

  localparam int NUM_CH       = 4;
  localparam int CFG_W        = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int DRAIN_CYCLES = 3;
  localparam int VW           = 4 * NUM_CH + 1;
  localparam logic [VW-1:0] RST_VAL =
    {1'b0, {NUM_CH{1'b0}}, {NUM_CH{1'b0}}, {NUM_CH{1'b1}}, {NUM_CH{1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  io_bank_ctrl_if #(.NUM_CH(NUM_CH), .CFG_W(CFG_W)) bus ();

  io_bank_ctrl #(
    .NUM_CH       (NUM_CH),
    .CFG_W        (CFG_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .UserCLK (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: m_left counts busy cycles still to come (last one is the apply cycle).
  logic [NUM_CH*CFG_W-1:0] m_active, m_pending;
  logic [NUM_CH-1:0]       m_mask, m_reg_i, m_reg_t, nxt_i, nxt_t;
  int                      m_left;
  logic [NUM_CH-1:0]       q_hist[$];
  logic [NUM_CH-1:0]       exp_i_top, exp_t_top, exp_o, exp_q;
  logic                    exp_busy;

  task automatic model_reset();
    m_active  = '0;
    m_pending = '0;
    m_mask    = '0;
    m_reg_i   = '0;
    m_reg_t   = '1;
    m_left    = 0;
    q_hist.delete();
    for (int k = 0; k < SYNC_STAGES; k++) q_hist.push_back('0);
  endtask

  task automatic model_eval();
    logic [CFG_W-1:0] c;
    logic parked, ti, tt;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      c      = m_active[ch*CFG_W +: CFG_W];
      parked = !c[0] || (m_left != 0 && m_mask[ch]);
      ti     = bus.I[ch];
      tt     = c[3] ? 1'b0 : bus.T[ch];
      nxt_i[ch] = parked ? 1'b0 : ti;
      nxt_t[ch] = parked ? 1'b1 : tt;
      if (parked) begin
        exp_i_top[ch] = 1'b0;
        exp_t_top[ch] = 1'b1;
      end else if (c[2]) begin
        exp_i_top[ch] = m_reg_i[ch];
        exp_t_top[ch] = m_reg_t[ch];
      end else begin
        exp_i_top[ch] = ti;
        exp_t_top[ch] = tt;
      end
      exp_o[ch] = c[1] & bus.O_top[ch];
    end
    exp_q    = q_hist[0];
    exp_busy = (m_left != 0);
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] chg, zap;
    model_eval();
    m_reg_i = nxt_i;
    m_reg_t = nxt_t;
    zap = (m_left == 1) ? m_mask : '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!m_active[ch*CFG_W + 1]) zap[ch] = 1'b1;
      chg[ch] = (bus.ConfigBits[ch*CFG_W +: CFG_W] != m_active[ch*CFG_W +: CFG_W]);
    end
    q_hist.push_back(exp_o);
    void'(q_hist.pop_front());
    foreach (q_hist[k]) q_hist[k] = q_hist[k] & ~zap;
    if (m_left == 0) begin
      if (bus.ConfigBits != m_active) begin
        m_pending = bus.ConfigBits;
        m_mask    = chg;
        m_left    = DRAIN_CYCLES + 1;
      end
    end else if (m_left > 1) begin
      if (bus.ConfigBits != m_pending) begin
        m_pending = bus.ConfigBits;
        m_mask    = m_mask | chg;
        m_left    = DRAIN_CYCLES + 1;
      end else begin
        m_left--;
      end
    end else begin
      m_active = m_pending;
      m_left   = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic rand_data();
    bus.I     = NUM_CH'($urandom);
    bus.T     = NUM_CH'($urandom);
    bus.O_top = NUM_CH'($urandom);
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {bus.ReconfigBusy, bus.Q, bus.O, bus.T_top, bus.I_top};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_busy, exp_q, exp_o, exp_t_top, exp_i_top};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rand_data();
    #1;
    checks++;
    if (obs_vec() !== RST_VAL) begin
      fails++;
      $display("FAIL reset_held: got %h want %h", obs_vec(), RST_VAL);
    end
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      rand_data();
      #1;
      checks++;
      if (obs_vec() !== RST_VAL) begin
        fails++;
        $display("FAIL reset_idle[%0d]: got %h want %h", n, obs_vec(), RST_VAL);
      end
      tick();
    end
  endtask

  task automatic test_out_comb();
    int n;
    bus.ConfigBits[0 +: CFG_W] = 4'b0001;
    tick();
    n = 0;
    while (bus.ReconfigBusy === 1'b1 && n < 20) begin
      n++;
      rand_data();
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL comb_drain[%0d]: got %h want %h", n, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      fails++;
      $display("FAIL comb_busy_len: got %0d cycles want 4", n);
    end
    bus.I[0] = 1'b1;
    bus.T[0] = 1'b0;
    #1;
    checks++;
    if ({bus.T_top[0], bus.I_top[0]} !== 2'b01) begin
      fails++;
      $display("FAIL comb_drive: got T/I %b%b want 01", bus.T_top[0], bus.I_top[0]);
    end
    bus.I[0] = 1'b0;
    bus.T[0] = 1'b1;
    #1;
    checks++;
    if ({bus.T_top[0], bus.I_top[0]} !== 2'b10) begin
      fails++;
      $display("FAIL comb_release: got T/I %b%b want 10", bus.T_top[0], bus.I_top[0]);
    end
    tick();
  endtask

  task automatic test_out_reg();
    int n;
    bus.ConfigBits[CFG_W +: CFG_W] = 4'b0101;
    bus.I[1] = 1'b1;
    bus.T[1:0] = 2'b00;
    tick();
    n = 0;
    while (bus.ReconfigBusy === 1'b1 && n < 20) begin
      n++;
      bus.I[0] = n[0];
      #1;
      checks++;
      if ({bus.T_top[1:0], bus.I_top[1:0]} !== {2'b10, 1'b0, n[0]}) begin
        fails++;
        $display("FAIL reg_drain[%0d]: got T %b I %b want T 10 I 0%b",
                 n, bus.T_top[1:0], bus.I_top[1:0], n[0]);
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      fails++;
      $display("FAIL reg_busy_len: got %0d cycles want 4", n);
    end
    bus.I[1] = 1'b0;
    tick();
    bus.I[1] = 1'b1;
    #1;
    checks++;
    if ({bus.T_top[1], bus.I_top[1]} !== 2'b00) begin
      fails++;
      $display("FAIL reg_hold: got T/I %b%b want 00", bus.T_top[1], bus.I_top[1]);
    end
    tick();
    checks++;
    if ({bus.T_top[1], bus.I_top[1]} !== 2'b01) begin
      fails++;
      $display("FAIL reg_follow: got T/I %b%b want 01", bus.T_top[1], bus.I_top[1]);
    end
  endtask

  task automatic test_sync();
    int n;
    bus.O_top[2] = 1'b0;
    bus.ConfigBits[2*CFG_W +: CFG_W] = 4'b0010;
    tick();
    n = 0;
    while (bus.ReconfigBusy === 1'b1 && n < 20) begin
      n++;
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL sync_drain[%0d]: got %h want %h", n, obs_vec(), exp_vec());
      end
      tick();
    end
    tick();
    tick();
    bus.O_top[2] = 1'b1;
    #1;
    checks++;
    if ({bus.Q[2], bus.O[2]} !== 2'b01) begin
      fails++;
      $display("FAIL sync_edge0: got Q/O %b%b want 01", bus.Q[2], bus.O[2]);
    end
    tick();
    checks++;
    if ({bus.Q[2], bus.O[2]} !== 2'b01) begin
      fails++;
      $display("FAIL sync_edge1: got Q/O %b%b want 01", bus.Q[2], bus.O[2]);
    end
    tick();
    checks++;
    if ({bus.Q[2], bus.O[2]} !== 2'b11) begin
      fails++;
      $display("FAIL sync_edge2: got Q/O %b%b want 11", bus.Q[2], bus.O[2]);
    end
  endtask

  task automatic test_retrigger();
    int n;
    bus.ConfigBits[3*CFG_W +: CFG_W] = 4'b0001;
    tick();
    n = 0;
    while (bus.ReconfigBusy === 1'b1 && n < 30) begin
      n++;
      if (n == 2) bus.ConfigBits[3*CFG_W +: CFG_W] = 4'b0101;
      rand_data();
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL retrig_drain[%0d]: got %h want %h", n, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (n != 6) begin
      fails++;
      $display("FAIL retrig_busy_len: got %0d cycles want 6", n);
    end
    bus.I[3] = 1'b1;
    bus.T[3] = 1'b0;
    tick();
    bus.I[3] = 1'b0;
    #1;
    checks++;
    if (bus.I_top[3] !== 1'b1) begin
      fails++;
      $display("FAIL retrig_final_cfg: got I_top[3]=%b want 1 (registered)", bus.I_top[3]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bus.ConfigBits[0 +: CFG_W] = 4'b0111;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== RST_VAL) begin
      fails++;
      $display("FAIL mid_reset: got %h want %h", obs_vec(), RST_VAL);
    end
    tick();
    rst = 1'b0;
    tick();
    n = 0;
    while (bus.ReconfigBusy === 1'b1 && n < 20) begin
      n++;
      rand_data();
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL mid_redrain[%0d]: got %h want %h", n, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      fails++;
      $display("FAIL mid_busy_len: got %0d cycles want 4", n);
    end
  endtask

  task automatic test_random();
    int ch;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        ch = int'($urandom_range(0, NUM_CH - 1));
        bus.ConfigBits[ch*CFG_W +: CFG_W] = CFG_W'($urandom);
      end
      rand_data();
      #1;
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random[%0d]: got %h want %h cfg %h", k, obs_vec(), exp_vec(), bus.ConfigBits);
      end
      tick();
    end
  endtask

  initial begin
    bus.ConfigBits = '0;
    bus.I          = '0;
    bus.T          = '1;
    bus.O_top      = '0;
`ifdef IO_LOOPBACK_EN
    bus.Loopback   = '0;
`endif
    model_reset();
    #1;
    rst = 1'b1;
    test_reset();
    test_out_comb();
    test_out_reg();
    test_sync();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/io_bank_ctrl.md
Name: io_bank_ctrl

Overview:
- Parametrised multi-channel bidirectional IO bank for fabric edge tiles; successor to the fixed two-channel A/B pass-through IO BELs.
- Per-channel configurable direction, optional output registering, input synchroniser, and drive override.
- Glitch-safe reconfiguration FSM: channels whose config changes are tri-stated for a drain period before the new config is applied.
- Sits between the tile switch matrix (I/T/O/Q) and tile top-level pad pins (*_top); config comes from the tile config memory.

Parameters:
- NUM_CH, 4, number of IO channels (1..32)
- CFG_W, 4, config bits per channel (fixed layout, see Behaviour)
- SYNC_STAGES, 2, input synchroniser depth for Q (1..4)
- DRAIN_CYCLES, 3, cycles changed channels are held hi-Z before apply (1..15)

Ports:
- UserCLK  input  1  fabric user clock
- Reset  input  1  asynchronous, active-high reset
- ConfigBits  input  NUM_CH*CFG_W  static config from config memory; channel c uses bits [c*CFG_W +: CFG_W]
- I  input  NUM_CH  fabric data to pad
- T  input  NUM_CH  fabric tristate, 1 = hi-Z
- O  output  NUM_CH  pad data to fabric, combinational
- Q  output  NUM_CH  pad data to fabric, synchronised
- I_top  output  NUM_CH  pad drive data
- T_top  output  NUM_CH  pad tristate, 1 = hi-Z
- O_top  input  NUM_CH  pad input data
- ReconfigBusy  output  1  high while a reconfiguration is pending/in progress

Behaviour:
- Config fields per channel: bit0 OUT_EN, bit1 IN_EN, bit2 REG_OUT, bit3 DRV_FORCE (ignore T, always drive when OUT_EN).
- Reset (async assert, sync-free release): active_cfg=0 for all channels, pending_cfg=0, FSM=IDLE, drain counter=0, ReconfigBusy=0, output regs I=0/T=1, sync flops=0 -> I_top=0, T_top=all 1s, O=0, Q=0.
- Output path: OUT_EN=0 -> T_top=1, I_top=0. OUT_EN=1 -> t_eff = DRV_FORCE ? 0 : T[c]; REG_OUT=0: I_top=I, T_top=t_eff combinationally; REG_OUT=1: both registered, 1-cycle latency.
- Input path: IN_EN=0 -> O=0, sync chain held at 0. IN_EN=1 -> O=O_top combinationally; Q=O_top delayed SYNC_STAGES rising edges.
- FSM IDLE: if ConfigBits != active_cfg -> latch pending_cfg=ConfigBits, chg_mask=per-channel inequality, counter=DRAIN_CYCLES-1, go DRAIN, ReconfigBusy=1 from the next cycle.
- DRAIN: channels in chg_mask forced T_top=1, I_top=0, output regs reset to I=0/T=1; unchanged channels operate normally. If ConfigBits != pending_cfg: re-latch pending, recompute chg_mask (OR with old mask), reload counter. Counter==0 -> APPLY.
- APPLY (1 cycle): active_cfg<=pending_cfg; changed channels still forced hi-Z; sync chains of changed channels cleared; go IDLE. ConfigBits changes during APPLY are not captured there; IDLE detects them next cycle.
- ReconfigBusy=1 exactly in DRAIN and APPLY; minimum busy span is DRAIN_CYCLES+1 cycles.
- Reset mid-DRAIN/APPLY: immediate return to reset state; pending config discarded; re-detected after release.

Optional Feature:
- IO_LOOPBACK_EN defined: extra input port Loopback [NUM_CH]; Loopback[c]=1 forces T_top[c]=1 and feeds O/Q from the channel's internal drive value (post REG_OUT stage) instead of O_top; IN_EN still gates O/Q. Loopback is ignored (treated 0) on channels in chg_mask during DRAIN/APPLY.
- Not defined: no Loopback port; O/Q always sourced from O_top.

Decomposition:
- Package io_bank_pkg: CFG_W, bit indices CFG_OUT_EN/CFG_IN_EN/CFG_REG_OUT/CFG_DRV_FORCE, FSM state enum {IDLE, DRAIN, APPLY}.
- Sub-module io_bank_channel: per-channel output mux/registers, hi-Z force input, sync chain with clear; instantiated NUM_CH times. FSM and masks stay in io_bank_ctrl.

Test Plan:
- Reset with ConfigBits=0 -> T_top=4'hF, I_top=0, O=0, Q=0, ReconfigBusy=0; hold 5 cycles, no change.
- Ch0 cfg 4'b0001 from 0 -> ReconfigBusy high 4 cycles (DRAIN 3 + APPLY 1); then I[0]=1,T[0]=0 -> I_top[0]=1,T_top[0]=0 same cycle.
- Ch1 cfg 4'b0101, toggle I[1] 0->1 -> I_top[1] follows 1 cycle later; ch0 output unaffected during ch1 drain.
- Ch2 cfg 4'b0010, O_top[2] 0->1 -> O[2]=1 immediately, Q[2]=1 after exactly 2 edges.
- ConfigBits changed again at DRAIN cycle 2 -> counter restarts, busy total 6 cycles, final active_cfg = second value.
- Reset asserted mid-DRAIN -> outputs return to reset values asynchronously; after release, new config applied via fresh 4-cycle sequence.
